// File: rtl/gcn_phase_scheduler.sv
// Phase sequencer for the GCN inference datapath: launches transformation, waits for
// combination, reads the result memory row by row and emits one argmax class per node.
module gcn_phase_scheduler #(
    parameter int FEATURE_ROWS   = 6,
    parameter int NUM_OF_NODES   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
    parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           start,
    output logic                                           start_trans,
    input  logic                                           done_trans,
    input  logic                                           done_comb,
    output logic [FEATURE_WIDTH-1:0]                       read_row_adj,
    input  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]     fm_wm_adj_out,
    output logic                                           class_valid,
    output logic [FEATURE_WIDTH-1:0]                       class_node,
    output logic [WEIGHT_WIDTH-1:0]                        class_idx,
    output logic                                           busy,
    output logic                                           done_gcn,
    output logic                                           error
);

    localparam int                       CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0]     CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [FEATURE_WIDTH-1:0] ROW_LAST  = FEATURE_WIDTH'(NUM_OF_NODES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRANS = 3'd1,
        S_COMB  = 3'd2,
        S_READ  = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [FEATURE_WIDTH-1:0] row_q, row_d;
    logic                     v1_q;
    logic [FEATURE_WIDTH-1:0] node1_q;
    logic                     start_trans_q, class_valid_q, busy_q, done_gcn_q, error_q;
    logic [FEATURE_WIDTH-1:0] class_node_q;
    logic [WEIGHT_WIDTH-1:0]  class_idx_q;
    logic [WEIGHT_WIDTH-1:0]  argmax_s;

    // Strictly-greater update keeps the lowest index on ties.
    function automatic logic [WEIGHT_WIDTH-1:0] argmax_f(
        input logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] row
    );
        logic signed [DOT_PROD_WIDTH-1:0] best;
        logic [WEIGHT_WIDTH-1:0]          idx;
        best = row[0];
        idx  = '0;
        for (int i = 1; i < WEIGHT_COLS; i++) begin
            if ($signed(row[i]) > best) begin
                best = row[i];
                idx  = WEIGHT_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    assign argmax_s = argmax_f(fm_wm_adj_out);

    // Next-state, phase counter and read address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        row_d   = '0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_TRANS;
                else       state_d = S_IDLE;
            end
            S_TRANS: begin
                if (done_trans) begin
                    state_d = S_COMB;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_TRANS;
                end
            end
            S_COMB: begin
                if (done_comb) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_COMB;
                end
            end
            S_READ: begin
                if (row_q == ROW_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    row_d = row_q + FEATURE_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_WIDTH'(1)) state_d = S_DONE;
                else                        state_d = S_DRAIN;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = cnt_q;
            end
            S_ERR: begin
                state_d = S_ERR;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, 2-stage class pipeline and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            row_q         <= '0;
            v1_q          <= 1'b0;
            node1_q       <= '0;
            start_trans_q <= 1'b0;
            class_valid_q <= 1'b0;
            class_node_q  <= '0;
            class_idx_q   <= '0;
            busy_q        <= 1'b0;
            done_gcn_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            v1_q          <= (state_q == S_READ);
            node1_q       <= row_q;
            start_trans_q <= (state_q == S_IDLE) && start;
            class_valid_q <= v1_q;
            class_node_q  <= v1_q ? node1_q : '0;
            class_idx_q   <= v1_q ? argmax_s : '0;
            busy_q        <= (state_d inside {S_TRANS, S_COMB, S_READ, S_DRAIN});
            done_gcn_q    <= (state_d == S_DONE);
            error_q       <= (state_d == S_ERR);
        end
    end

    assign start_trans  = start_trans_q;
    assign read_row_adj = row_q;
    assign class_valid  = class_valid_q;
    assign class_node   = class_node_q;
    assign class_idx    = class_idx_q;
    assign busy         = busy_q;
    assign done_gcn     = done_gcn_q;
    assign error        = error_q;

endmodule

// File: tb/tb_gcn_phase_scheduler.sv
// Self-checking bench for gcn_phase_scheduler: scenario tasks compare observed pulses
// and class results against a timing/argmax model derived from the sequencing rules.
module tb_gcn_phase_scheduler;

    localparam int FR = 6;
    localparam int NN = 6;
    localparam int WC = 3;
    localparam int DW = 16;
    localparam int TO = 15;
    localparam int FW = $clog2(FR);
    localparam int WW = $clog2(WC);

    logic clk = 1'b0;
    logic reset, start, done_trans, done_comb;
    logic start_trans, class_valid, busy, done_gcn, error;
    logic [FW-1:0] read_row_adj, class_node;
    logic [WW-1:0] class_idx;
    logic [0:WC-1][DW-1:0] fm_wm_adj_out;
    logic [5+2*FW+WW-1:0] outv;

    int mem [FR][WC];
    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        int node;
        int idx;
    } cls_t;
    cls_t q_cls [$];
    int   q_st  [$];
    int   q_done[$];
    cls_t ent;

    gcn_phase_scheduler #(
        .FEATURE_ROWS(FR), .NUM_OF_NODES(NN), .WEIGHT_COLS(WC),
        .DOT_PROD_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .start_trans(start_trans),
        .done_trans(done_trans), .done_comb(done_comb), .read_row_adj(read_row_adj),
        .fm_wm_adj_out(fm_wm_adj_out), .class_valid(class_valid), .class_node(class_node),
        .class_idx(class_idx), .busy(busy), .done_gcn(done_gcn), .error(error)
    );

    assign outv = {start_trans, class_valid, busy, done_gcn, error, read_row_adj, class_node, class_idx};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Result memory with one cycle of read latency.
    always @(posedge clk) begin
        for (int c = 0; c < WC; c++)
            fm_wm_adj_out[c] <= (int'(read_row_adj) < FR) ? DW'(mem[read_row_adj][c]) : '0;
    end

    always @(negedge clk) begin
        if (class_valid) begin
            ent.cyc  = cyc;
            ent.node = int'(class_node);
            ent.idx  = int'(class_idx);
            q_cls.push_back(ent);
        end
        if (start_trans) q_st.push_back(cyc);
        if (done_gcn)    q_done.push_back(cyc);
    end

    // Reference argmax: find the maximum value, then its first occurrence.
    function automatic int ref_argmax(input int r);
        int mx;
        mx = mem[r][0];
        for (int c = 1; c < WC; c++) if (mem[r][c] > mx) mx = mem[r][c];
        for (int c = 0; c < WC; c++) if (mem[r][c] == mx) return c;
        return 0;
    endfunction

    task automatic fill_fixed();
        int tab [FR*WC] = '{3, 7, 1, -2, -5, -1, 4, 4, 0, 0, 0, 9, -8, 2, 2, 1, 0, 0};
        for (int r = 0; r < FR; r++)
            for (int c = 0; c < WC; c++) mem[r][c] = tab[r*WC + c];
    endtask

    task automatic fill_random(input int mode);
        for (int r = 0; r < FR; r++)
            for (int c = 0; c < WC; c++)
                mem[r][c] = (mode % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                            : int'($urandom_range(0, 4)) - 2;
    endtask

    // From IDLE at a negedge: start, done_trans dt edges later, done_comb dc edges after that.
    task automatic drive_to_read(input int dt, input int dc, output int e0, output int c);
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
        repeat (dt - 1) @(negedge clk);
        done_trans = 1'b1;
        @(negedge clk);
        done_trans = 1'b0;
        repeat (dc - 1) @(negedge clk);
        done_comb = 1'b1;
        @(negedge clk);
        c = cyc;
        done_comb = 1'b0;
    endtask

    task automatic drive_run(input int dt, input int dc, output int e0, output int c);
        drive_to_read(dt, dc, e0, c);
        repeat (NN + 5) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; done_trans = 1'b0; done_comb = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (outv !== '0) $display("FAIL reset_outputs: got %h expected 0", outv);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (outv !== '0) $display("FAIL post_reset_idle: got %h expected 0", outv);
        else passed++;
    endtask

    task automatic test_nominal();
        int exp_nom [NN] = '{1, 2, 0, 2, 1, 0};
        int e0, c, bc, bs, bd;
        fill_fixed();
        bc = q_cls.size(); bs = q_st.size(); bd = q_done.size();
        drive_run(5, 8, e0, c);
        total++;
        if (q_cls.size() - bc !== NN) $display("FAIL nom_count: got %0d expected %0d", q_cls.size() - bc, NN);
        else passed++;
        for (int r = 0; r < NN && bc + r < q_cls.size(); r++) begin
            total++;
            if (q_cls[bc+r].idx !== exp_nom[r] || q_cls[bc+r].node !== r || q_cls[bc+r].cyc !== c + 2 + r)
                $display("FAIL nom_row%0d: got idx %0d node %0d cyc %0d expected idx %0d node %0d cyc %0d",
                         r, q_cls[bc+r].idx, q_cls[bc+r].node, q_cls[bc+r].cyc, exp_nom[r], r, c + 2 + r);
            else passed++;
        end
        total++;
        if (q_st.size() - bs !== 1 || q_st[bs] !== e0)
            $display("FAIL nom_start_trans: got %0d pulses first at %0d expected 1 at %0d", q_st.size() - bs, q_st[bs], e0);
        else passed++;
        total++;
        if (q_done.size() - bd !== 1 || q_done[bd] !== c + NN + 2)
            $display("FAIL nom_done: got %0d pulses first at %0d expected 1 at %0d", q_done.size() - bd, q_done[bd], c + NN + 2);
        else passed++;
    endtask

    task automatic test_random_runs();
        for (int k = 0; k < 4; k++) begin
            int dt, dc, e0, c, bc, bd;
            fill_random(k);
            dt = int'($urandom_range(1, TO));
            dc = int'($urandom_range(1, TO));
            bc = q_cls.size(); bd = q_done.size();
            drive_run(dt, dc, e0, c);
            total++;
            if (q_cls.size() - bc !== NN) $display("FAIL rnd%0d_count: got %0d expected %0d", k, q_cls.size() - bc, NN);
            else passed++;
            for (int r = 0; r < NN && bc + r < q_cls.size(); r++) begin
                total++;
                if (q_cls[bc+r].idx !== ref_argmax(r) || q_cls[bc+r].node !== r || q_cls[bc+r].cyc !== c + 2 + r)
                    $display("FAIL rnd%0d_row%0d: got idx %0d node %0d cyc %0d expected idx %0d node %0d cyc %0d",
                             k, r, q_cls[bc+r].idx, q_cls[bc+r].node, q_cls[bc+r].cyc, ref_argmax(r), r, c + 2 + r);
                else passed++;
            end
            total++;
            if (q_done.size() - bd !== 1 || q_done[bd] !== c + NN + 2 || error !== 1'b0)
                $display("FAIL rnd%0d_done: got %0d pulses at %0d err %0b expected 1 at %0d err 0",
                         k, q_done.size() - bd, q_done[bd], error, c + NN + 2);
            else passed++;
        end
    endtask

    task automatic test_spurious();
        int e0, c, bc, bs, bd, bad;
        fill_random(0);
        bc = q_cls.size(); bs = q_st.size(); bd = q_done.size();
        done_trans = 1'b1; done_comb = 1'b1;
        repeat (4) @(negedge clk);
        done_trans = 1'b0; done_comb = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || q_st.size() !== bs || q_cls.size() !== bc || q_done.size() !== bd)
            $display("FAIL spur_idle: got busy %0b st %0d cls %0d done %0d expected 0 %0d %0d %0d",
                     busy, q_st.size(), q_cls.size(), q_done.size(), bs, bc, bd);
        else passed++;
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
        repeat (2) @(negedge clk);
        done_trans = 1'b1;
        @(negedge clk);
        done_trans = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            start      = (i % 2 == 0);
            done_trans = (i % 2 == 1);
            @(negedge clk);
            if (busy !== 1'b1 || class_valid !== 1'b0 || read_row_adj !== '0) bad++;
        end
        start = 1'b0; done_trans = 1'b0;
        total++;
        if (bad !== 0) $display("FAIL spur_comb_hold: got %0d bad cycles expected 0", bad);
        else passed++;
        done_comb = 1'b1;
        @(negedge clk);
        c = cyc;
        done_comb = 1'b0;
        repeat (NN + 5) @(negedge clk);
        total++;
        if (q_st.size() - bs !== 1 || q_st[bs] !== e0)
            $display("FAIL spur_start_trans: got %0d pulses expected 1 at %0d", q_st.size() - bs, e0);
        else passed++;
        total++;
        if (q_cls.size() - bc !== NN || q_cls[bc].cyc !== c + 2 || q_done.size() - bd !== 1 || q_done[bd] !== c + NN + 2)
            $display("FAIL spur_run: got %0d results first at %0d done at %0d expected %0d at %0d done at %0d",
                     q_cls.size() - bc, q_cls[bc].cyc, q_done[bd], NN, c + 2, c + NN + 2);
        else passed++;
    endtask

    task automatic test_trans_timeout();
        int e0, bs;
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
        repeat (14) @(negedge clk);
        total++;
        if (error !== 1'b0 || busy !== 1'b1)
            $display("FAIL tto_before: got err %0b busy %0b at +%0d expected 0 1", error, busy, cyc - e0);
        else passed++;
        @(negedge clk);
        total++;
        if (error !== 1'b1 || busy !== 1'b0)
            $display("FAIL tto_enter: got err %0b busy %0b at +%0d expected 1 0", error, busy, cyc - e0);
        else passed++;
        bs = q_st.size();
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (error !== 1'b1 || busy !== 1'b0 || q_st.size() !== bs)
            $display("FAIL tto_sticky: got err %0b busy %0b st %0d expected 1 0 %0d", error, busy, q_st.size(), bs);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (error !== 1'b0) $display("FAIL tto_reset: got err %0b expected 0", error);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_comb_timeout();
        int e0, c, t, bc, bd;
        fill_random(1);
        bd = q_done.size();
        drive_run(2, 15, e0, c);
        total++;
        if (error !== 1'b0 || q_done.size() - bd !== 1 || q_done[bd] !== c + NN + 2)
            $display("FAIL cto_15th: got err %0b done %0d at %0d expected 0 1 at %0d", error, q_done.size() - bd, q_done[bd], c + NN + 2);
        else passed++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_trans = 1'b1;
        @(negedge clk);
        t = cyc;
        done_trans = 1'b0;
        repeat (14) @(negedge clk);
        total++;
        if (error !== 1'b0 || busy !== 1'b1) $display("FAIL cto_before: got err %0b busy %0b expected 0 1", error, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (error !== 1'b1) $display("FAIL cto_16th: got err %0b at +%0d expected 1", error, cyc - t);
        else passed++;
        bc = q_cls.size();
        done_comb = 1'b1;
        @(negedge clk);
        done_comb = 1'b0;
        repeat (NN + 3) @(negedge clk);
        total++;
        if (error !== 1'b1 || busy !== 1'b0 || q_cls.size() !== bc)
            $display("FAIL cto_hold: got err %0b busy %0b cls %0d expected 1 0 %0d", error, busy, q_cls.size(), bc);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int e0, c, bc, bd;
        fill_random(0);
        drive_to_read(2, 2, e0, c);
        repeat (3) @(negedge clk);
        total++;
        if (read_row_adj !== FW'(3) || class_valid !== 1'b1)
            $display("FAIL mid_read_pre: got row %0d valid %0b expected 3 1", read_row_adj, class_valid);
        else passed++;
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (outv !== '0) $display("FAIL mid_read_async: got %h expected 0", outv);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || class_valid !== 1'b0) $display("FAIL mid_read_idle: got busy %0b valid %0b expected 0 0", busy, class_valid);
        else passed++;
        bc = q_cls.size(); bd = q_done.size();
        drive_run(3, 4, e0, c);
        total++;
        if (q_cls.size() - bc !== NN || q_cls[bc+NN-1].idx !== ref_argmax(NN-1) || q_done.size() - bd !== 1 || q_done[bd] !== c + NN + 2)
            $display("FAIL mid_read_rerun: got %0d results last idx %0d done at %0d expected %0d %0d at %0d",
                     q_cls.size() - bc, q_cls[bc+NN-1].idx, q_done[bd], NN, ref_argmax(NN-1), c + NN + 2);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int k, e0a, c1, e0b, c2, bc, bs, bd, ec;
        fill_random(1);
        bc = q_cls.size(); bs = q_st.size(); bd = q_done.size();
        k = cyc;
        start = 1'b1; done_trans = 1'b1; done_comb = 1'b1;
        repeat (2*NN + 11) @(negedge clk);
        start = 1'b0; done_trans = 1'b0; done_comb = 1'b0;
        repeat (NN + 5) @(negedge clk);
        e0a = k + 1;
        c1  = e0a + 2;
        e0b = c1 + NN + 4;
        c2  = e0b + 2;
        total++;
        if (q_st.size() - bs !== 2 || q_st[bs] !== e0a || q_st[bs+1] !== e0b)
            $display("FAIL b2b_start_trans: got %0d pulses at %0d %0d expected 2 at %0d %0d",
                     q_st.size() - bs, q_st[bs], q_st[bs+1], e0a, e0b);
        else passed++;
        total++;
        if (q_done.size() - bd !== 2 || q_done[bd] !== c1 + NN + 2 || q_done[bd+1] !== c2 + NN + 2)
            $display("FAIL b2b_done: got %0d pulses at %0d %0d expected 2 at %0d %0d",
                     q_done.size() - bd, q_done[bd], q_done[bd+1], c1 + NN + 2, c2 + NN + 2);
        else passed++;
        total++;
        if (q_cls.size() - bc !== 2*NN) $display("FAIL b2b_count: got %0d expected %0d", q_cls.size() - bc, 2*NN);
        else passed++;
        for (int i = 0; i < 2*NN && bc + i < q_cls.size(); i++) begin
            ec = ((i < NN) ? c1 : c2) + 2 + (i % NN);
            total++;
            if (q_cls[bc+i].idx !== ref_argmax(i % NN) || q_cls[bc+i].node !== i % NN || q_cls[bc+i].cyc !== ec)
                $display("FAIL b2b_res%0d: got idx %0d node %0d cyc %0d expected idx %0d node %0d cyc %0d",
                         i, q_cls[bc+i].idx, q_cls[bc+i].node, q_cls[bc+i].cyc, ref_argmax(i % NN), i % NN, ec);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_random_runs();
        test_spurious();
        test_trans_timeout();
        test_comb_timeout();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
